// File: rtl/banked_sync_ram_pkg.sv
// Shared types and constants for the banked GBC work/video RAM.
package gb_mem_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } ram_state_t;

    localparam int DEFAULT_BANK = 1;

endpackage

// File: rtl/banked_sync_ram_if.sv
// Port bundle for banked_sync_ram: CPU window port, bank register, read-only port B, status.
// Handshake: no valid/ready pairing; a port acts on every posedge, and READY=0 means writes are dropped and read data is forced to zero.
interface banked_sync_ram_if #(
    parameter int ADDR_SIZE = 13,
    parameter int DATA_SIZE = 8,
    parameter int BANKS     = 8
);
    import gb_mem_pkg::*;

    localparam int BANK_BITS = $clog2(BANKS);
    localparam int PHYS_BITS = BANK_BITS + ADDR_SIZE - 1;

    logic                 A_WE;
    logic                 A_HOLD;
    logic [ADDR_SIZE-1:0] A_ADDR;
    logic [DATA_SIZE-1:0] A_DIN;
    logic [DATA_SIZE-1:0] A_DOUT;
    logic                 BANK_WE;
    logic [BANK_BITS-1:0] BANK_DIN;
    logic [BANK_BITS-1:0] BANK_SEL;
    logic                 B_HOLD;
    logic [PHYS_BITS-1:0] B_ADDR;
    logic [DATA_SIZE-1:0] B_DOUT;
    logic                 READY;
    ram_state_t           STATE;

    modport master (
        output A_WE, A_HOLD, A_ADDR, A_DIN, BANK_WE, BANK_DIN, B_HOLD, B_ADDR,
        input  A_DOUT, BANK_SEL, B_DOUT, READY, STATE
    );

    modport slave (
        input  A_WE, A_HOLD, A_ADDR, A_DIN, BANK_WE, BANK_DIN, B_HOLD, B_ADDR,
        output A_DOUT, BANK_SEL, B_DOUT, READY, STATE
    );

endinterface

// File: rtl/banked_sync_ram_addr_map.sv
// Maps a CPU window address onto physical memory: lower half is bank 0, upper half the selected bank.
module banked_addr_map #(
    parameter int ADDR_SIZE = 13,
    parameter int BANK_BITS = 3,
    parameter int PHYS_BITS = BANK_BITS + ADDR_SIZE - 1
) (
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [BANK_BITS-1:0] bank,
    output logic [PHYS_BITS-1:0] phys
);

    always_comb begin
        if (addr[ADDR_SIZE-1])
            phys = {bank, addr[ADDR_SIZE-2:0]};
        else
            phys = {{BANK_BITS{1'b0}}, addr[ADDR_SIZE-2:0]};
    end

endmodule

// File: rtl/banked_sync_ram.sv
// Banked dual-port RAM with a CPU window, a physical read port and a zeroing engine that runs after reset.
module banked_sync_ram
    import gb_mem_pkg::*;
#(
    parameter int ADDR_SIZE      = 13,
    parameter int DATA_SIZE      = 8,
    parameter int BANKS          = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    banked_sync_ram_if.slave  bus
);

    localparam int BANK_BITS = $clog2(BANKS);
    localparam int PHYS_BITS = BANK_BITS + ADDR_SIZE - 1;
    localparam int DEPTH     = 2 ** PHYS_BITS;

    ram_state_t           state;
    logic                 ready;
    logic [PHYS_BITS-1:0] clr_addr;
    logic [BANK_BITS-1:0] bank_sel;
    logic [PHYS_BITS-1:0] phys_a;
    logic [DATA_SIZE-1:0] a_dout;
    logic [DATA_SIZE-1:0] b_dout;

    logic                 wr_en;
    logic [PHYS_BITS-1:0] wr_addr;
    logic [DATA_SIZE-1:0] wr_data;

    logic [DATA_SIZE-1:0] mem [0:DEPTH-1];

    banked_addr_map #(
        .ADDR_SIZE (ADDR_SIZE),
        .BANK_BITS (BANK_BITS),
        .PHYS_BITS (PHYS_BITS)
    ) u_map (
        .addr (bus.A_ADDR),
        .bank (bank_sel),
        .phys (phys_a)
    );

    // The single write port is shared: the clear engine owns it until READY.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = phys_a;
        wr_data = bus.A_DIN;
        if (state == S_CLEAR) begin
            wr_en   = !RST;
            wr_addr = clr_addr;
            wr_data = '0;
        end else if (ready && bus.A_WE && !RST) begin
            wr_en   = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
            clr_addr <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_addr == PHYS_BITS'(DEPTH - 1)) begin
                        state <= S_READY;
                        ready <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: ready <= 1'b1;
            endcase
        end
    end

    // Bank 0 is never mapped into the upper half; a request for it selects bank 1.
    always_ff @(posedge CLK) begin
        if (RST)
            bank_sel <= BANK_BITS'(DEFAULT_BANK);
        else if (bus.BANK_WE)
            bank_sel <= (bus.BANK_DIN == '0) ? BANK_BITS'(DEFAULT_BANK) : bus.BANK_DIN;
    end

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge CLK) begin
        if (RST || !ready)
            a_dout <= '0;
        else if (!bus.A_HOLD)
            a_dout <= mem[phys_a];
    end

    always_ff @(posedge CLK) begin
        if (RST || !ready)
            b_dout <= '0;
        else if (!bus.B_HOLD)
            b_dout <= mem[bus.B_ADDR];
    end

    assign bus.A_DOUT   = a_dout;
    assign bus.B_DOUT   = b_dout;
    assign bus.BANK_SEL = bank_sel;
    assign bus.READY    = ready;
    assign bus.STATE    = state;

endmodule

// File: tb/tb_banked_sync_ram.sv
// Self-checking bench for banked_sync_ram: directed vector table, hand sequences and a random run against a reference model.
module tb_banked_sync_ram;
    import gb_mem_pkg::*;

    localparam int AS    = 13;
    localparam int DS    = 8;
    localparam int NB    = 8;
    localparam int HALF  = 4096;
    localparam int DEPTH = 32768;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    banked_sync_ram_if #(.ADDR_SIZE(AS), .DATA_SIZE(DS), .BANKS(NB)) bus ();

    banked_sync_ram #(
        .ADDR_SIZE      (AS),
        .DATA_SIZE      (DS),
        .BANKS          (NB),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] mdl_mem [0:DEPTH-1];
    int         mdl_bank;
    logic [7:0] mdl_a;
    logic [7:0] mdl_b;
    logic [7:0] exp_q [$];

    typedef struct {
        logic        we;
        logic        hold;
        logic [12:0] addr;
        logic [7:0]  din;
        logic        bwe;
        logic [2:0]  bdin;
        logic        bhold;
        logic [14:0] baddr;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [2:0]  ebank;
    } vec_t;

    vec_t vt [20];

    function automatic vec_t mk(input logic we, input logic hold, input logic [12:0] addr,
                                input logic [7:0] din, input logic bwe, input logic [2:0] bdin,
                                input logic bhold, input logic [14:0] baddr,
                                input logic [7:0] ea, input logic [7:0] eb, input logic [2:0] ebank);
        vec_t v;
        v.we = we; v.hold = hold; v.addr = addr; v.din = din; v.bwe = bwe; v.bdin = bdin;
        v.bhold = bhold; v.baddr = baddr; v.ea = ea; v.eb = eb; v.ebank = ebank;
        return v;
    endfunction

    function automatic int phys_of(input int addr, input int bank);
        return (addr >= HALF) ? bank * HALF + (addr % HALF) : addr;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.A_WE = 1'b0; bus.A_HOLD = 1'b0; bus.A_ADDR = '0; bus.A_DIN = '0;
        bus.BANK_WE = 1'b0; bus.BANK_DIN = '0; bus.B_HOLD = 1'b0; bus.B_ADDR = '0;
    endtask

    task automatic model_clear(input int bank);
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
        mdl_bank = bank;
        mdl_a = 8'h00;
        mdl_b = 8'h00;
    endtask

    // One clock cycle of stimulus with the reference model stepped alongside.
    task automatic cyc(input logic we, input logic hold, input logic [12:0] addr, input logic [7:0] din,
                       input logic bwe, input logic [2:0] bdin, input logic bhold, input logic [14:0] baddr);
        int pa;
        bus.A_WE = we; bus.A_HOLD = hold; bus.A_ADDR = addr; bus.A_DIN = din;
        bus.BANK_WE = bwe; bus.BANK_DIN = bdin; bus.B_HOLD = bhold; bus.B_ADDR = baddr;
        pa = phys_of(int'(addr), mdl_bank);
        if (!hold)  mdl_a = mdl_mem[pa];
        if (!bhold) mdl_b = mdl_mem[int'(baddr)];
        if (we)     mdl_mem[pa] = din;
        if (bwe)    mdl_bank = (bdin == 3'd0) ? 1 : int'(bdin);
        tick();
    endtask

    // Run the clear with random port-B reads, a stray CPU write and an optional bank load.
    task automatic wait_ready(input bit do_bank, output int n);
        n = 0;
        while (bus.READY !== 1'b1 && n < 40000) begin
            bus.B_ADDR  = 15'($urandom_range(0, DEPTH - 1));
            bus.A_WE    = (n >= 100);
            bus.A_ADDR  = 13'h0003;
            bus.A_DIN   = 8'hEE;
            bus.BANK_WE = do_bank && (n == 200);
            bus.BANK_DIN = 3'd6;
            tick();
            n++;
            if (n % 4096 == 0 && bus.READY !== 1'b1) chk("clear_b_dout_zero", bus.B_DOUT, 0);
        end
        idle_inputs();
    endtask

    initial begin
        int n;
        logic [7:0] exp_a;
        idle_inputs();
        vt[0]  = mk(0, 0, 13'h0003, 8'h00, 0, 3'd0, 0, 15'h0003, 8'h00, 8'h00, 3'd6);
        vt[1]  = mk(0, 0, 13'h0000, 8'h00, 1, 3'd0, 0, 15'h0000, 8'h00, 8'h00, 3'd1);
        vt[2]  = mk(0, 0, 13'h0000, 8'h00, 1, 3'd5, 0, 15'h0000, 8'h00, 8'h00, 3'd5);
        vt[3]  = mk(1, 0, 13'h1010, 8'hA5, 0, 3'd0, 0, 15'h5010, 8'h00, 8'h00, 3'd5);
        vt[4]  = mk(0, 0, 13'h1010, 8'h00, 0, 3'd0, 0, 15'h5010, 8'hA5, 8'hA5, 3'd5);
        vt[5]  = mk(0, 0, 13'h1010, 8'h00, 0, 3'd0, 0, 15'h1010, 8'hA5, 8'h00, 3'd5);
        vt[6]  = mk(0, 0, 13'h0020, 8'h00, 1, 3'd3, 0, 15'h0020, 8'h00, 8'h00, 3'd3);
        vt[7]  = mk(1, 0, 13'h0020, 8'h3C, 0, 3'd0, 0, 15'h0020, 8'h00, 8'h00, 3'd3);
        vt[8]  = mk(0, 0, 13'h0020, 8'h00, 0, 3'd0, 0, 15'h0020, 8'h3C, 8'h3C, 3'd3);
        vt[9]  = mk(0, 0, 13'h0020, 8'h00, 1, 3'd7, 0, 15'h0020, 8'h3C, 8'h3C, 3'd7);
        vt[10] = mk(0, 0, 13'h0020, 8'h00, 0, 3'd0, 0, 15'h7020, 8'h3C, 8'h00, 3'd7);
        vt[11] = mk(1, 0, 13'h1100, 8'h11, 0, 3'd0, 0, 15'h7100, 8'h00, 8'h00, 3'd7);
        vt[12] = mk(1, 0, 13'h1100, 8'h77, 0, 3'd0, 0, 15'h7100, 8'h11, 8'h11, 3'd7);
        vt[13] = mk(0, 0, 13'h1100, 8'h00, 0, 3'd0, 0, 15'h7100, 8'h77, 8'h77, 3'd7);
        vt[14] = mk(0, 0, 13'h0000, 8'h00, 1, 3'd5, 0, 15'h5010, 8'h00, 8'hA5, 3'd5);
        vt[15] = mk(0, 0, 13'h1010, 8'h00, 0, 3'd0, 0, 15'h5010, 8'hA5, 8'hA5, 3'd5);
        vt[16] = mk(0, 1, 13'h0020, 8'h00, 0, 3'd0, 1, 15'h0020, 8'hA5, 8'hA5, 3'd5);
        vt[17] = mk(0, 1, 13'h1100, 8'h00, 0, 3'd0, 0, 15'h0020, 8'hA5, 8'h3C, 3'd5);
        vt[18] = mk(0, 0, 13'h0020, 8'h00, 0, 3'd0, 1, 15'h7100, 8'h3C, 8'h3C, 3'd5);
        vt[19] = mk(0, 1, 13'h0000, 8'h00, 0, 3'd0, 0, 15'h7100, 8'h3C, 8'h77, 3'd5);

        // Reset for one cycle, then the full clear.
        rst = 1'b1;
        tick();
        chk("rst_ready", bus.READY, 0);
        chk("rst_a_dout", bus.A_DOUT, 0);
        chk("rst_b_dout", bus.B_DOUT, 0);
        chk("rst_bank_sel", bus.BANK_SEL, 1);
        chk("rst_state", bus.STATE, S_CLEAR);
        rst = 1'b0;
        wait_ready(1'b1, n);
        chk("clear_cycles", n, DEPTH);
        chk("bank_we_during_clear", bus.BANK_SEL, 6);
        chk("ready_state", bus.STATE, S_READY);
        model_clear(6);

        for (int i = 0; i < 20; i++) begin
            cyc(vt[i].we, vt[i].hold, vt[i].addr, vt[i].din, vt[i].bwe, vt[i].bdin, vt[i].bhold, vt[i].baddr);
            chk($sformatf("vec%0d_a_dout", i), bus.A_DOUT, vt[i].ea);
            chk($sformatf("vec%0d_b_dout", i), bus.B_DOUT, vt[i].eb);
            chk($sformatf("vec%0d_bank", i), bus.BANK_SEL, vt[i].ebank);
        end

        // Random traffic on a small address pool so reads hit recent writes.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                13'(($urandom_range(0, 1) << 12) | $urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
                15'(($urandom_range(0, 7) << 12) | $urandom_range(0, 15)));
            exp_q.push_back(mdl_a);
            exp_a = exp_q.pop_front();
            chk("rand_a_dout", bus.A_DOUT, exp_a);
            chk("rand_b_dout", bus.B_DOUT, mdl_b);
            chk("rand_bank", bus.BANK_SEL, mdl_bank);
        end

        // Reset during operation, then again 1000 cycles into the clear.
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            bus.BANK_WE  = (i == 10);
            bus.BANK_DIN = 3'd2;
            tick();
        end
        idle_inputs();
        chk("midclear_ready", bus.READY, 0);
        chk("midclear_bank", bus.BANK_SEL, 2);
        rst = 1'b1;
        tick();
        chk("rst2_bank_sel", bus.BANK_SEL, 1);
        chk("rst2_ready", bus.READY, 0);
        chk("rst2_state", bus.STATE, S_CLEAR);
        rst = 1'b0;
        wait_ready(1'b0, n);
        chk("clear2_cycles", n, DEPTH);
        chk("clear2_bank", bus.BANK_SEL, 1);
        model_clear(1);

        // Bank load on the same edge as an upper-half write: the old bank takes the write.
        cyc(1, 0, 13'h1234, 8'h5A, 1, 3'd4, 0, 15'h1234);
        chk("samedge_a_old", bus.A_DOUT, 8'h00);
        chk("samedge_bank", bus.BANK_SEL, 4);
        cyc(0, 0, 13'h1234, 8'h00, 0, 3'd0, 0, 15'h1234);
        chk("samedge_b_oldbank", bus.B_DOUT, 8'h5A);
        chk("samedge_a_newbank", bus.A_DOUT, 8'h00);
        cyc(0, 0, 13'h0000, 8'h00, 0, 3'd0, 0, 15'h4234);
        chk("samedge_b_newbank", bus.B_DOUT, 8'h00);
        cyc(0, 0, 13'h0000, 8'h00, 0, 3'd0, 0, 15'h5010);
        chk("cleared_after_rst", bus.B_DOUT, 8'h00);
        chk("cleared_model", bus.B_DOUT, mdl_b);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
